decoder_2to4: RTL and testbench



---
 rtl/decoder_pkg.sv | 24 ++
 rtl/decoder_core.sv | 16 +
 rtl/decoder_2to4.sv | 71 +++++++
 tb/tb_decoder_2to4.sv | 134 +++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared definitions for the registered binary-to-one-hot decoder.
package decoder_pkg;

   localparam int unsigned DEC_IN_W_DEFAULT = 2;
   localparam int unsigned DEC_MAX_IN_W     = 6;
   localparam int unsigned DEC_MAX_OUT_W    = 64;

   // Reference decode at the widest supported size; callers keep the low OUT_W bits.
   function automatic logic [DEC_MAX_OUT_W-1:0] onehot_dec(input logic [DEC_MAX_IN_W-1:0] sel,
                                                           input logic                    en);
      logic [DEC_MAX_OUT_W-1:0] r;
      r = '0;
      for (int i = 0; i < DEC_MAX_OUT_W; i++) begin
         r[i] = en && (sel == DEC_MAX_IN_W'(i));
      end
      return r;
   endfunction

   // True when at most one bit of v is set.
   function automatic logic is_onehot0(input logic [DEC_MAX_OUT_W-1:0] v);
      return (v & (v - 1'b1)) == '0;
   endfunction

endpackage

// File: rtl/decoder_core.sv
// Purely combinational select decode: next_y = en ? (1 << a) : 0.
module decoder_core #(
   parameter int unsigned IN_W  = 2,
   parameter int unsigned OUT_W = 2 ** IN_W
) (
   input  logic [IN_W-1:0]  a_i,
   input  logic             en_i,
   output logic [OUT_W-1:0] next_y_o
);

   // One comparator per output line; only the line whose index equals a can fire.
   for (genvar i = 0; i < OUT_W; i++) begin : g_line
      assign next_y_o[i] = en_i && (a_i == IN_W'(i));
   end

endmodule

// File: rtl/decoder_2to4.sv
// Enable-gated binary-to-one-hot decoder with optional output register stage.
module decoder_2to4
   import decoder_pkg::*;
#(
   parameter int unsigned IN_W    = DEC_IN_W_DEFAULT,
   parameter int unsigned OUT_W   = 2 ** IN_W,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  a,
   input  logic             en,
   output logic [OUT_W-1:0] y,
   output logic             y_valid
);

   // OUT_W is derived; reject illegal widths or an independent override at elaboration.
   if (IN_W < 1 || IN_W > DEC_MAX_IN_W || OUT_W != 2 ** IN_W) begin : g_bad_param
      $error("decoder_2to4: IN_W must be 1..6 and OUT_W must equal 2**IN_W");
   end

   logic [OUT_W-1:0] next_y;

   decoder_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .a_i      (a),
      .en_i     (en),
      .next_y_o (next_y)
   );

   if (REG_OUT) begin : g_reg
      logic [OUT_W-1:0] y_d, y_q;
      logic             y_valid_d, y_valid_q;

      // Next-state: reset takes priority over any decode in the same cycle.
      always_comb begin
         y_d       = next_y;
         y_valid_d = en;
         if (rst) begin
            y_d       = '0;
            y_valid_d = 1'b0;
         end
      end

      // Output register; the only state in the block.
      always_ff @(posedge clk) begin
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
      end

      assign y       = y_q;
      assign y_valid = y_valid_q;
   end else begin : g_comb
      assign y       = next_y;
      assign y_valid = en;
   end

   // Cross-check the generate-loop decode against the package reference function.
   logic [DEC_MAX_OUT_W-1:0] ref_y_wide;
   assign ref_y_wide = onehot_dec(DEC_MAX_IN_W'(a), en);

   a_core_matches_ref: assert property (@(posedge clk)
      DEC_MAX_OUT_W'(next_y) == ref_y_wide);

   // Output must never be multi-hot once out of reset.
   a_y_onehot0: assert property (@(posedge clk) disable iff (rst)
      is_onehot0(DEC_MAX_OUT_W'(y)));

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed-vector bench for decoder_2to4 with a cycle-level reference model.
module tb_decoder_2to4;

   localparam int NVEC = 21;

   logic       clk;
   logic       rst;
   logic [1:0] a;
   logic       en;
   logic [3:0] y;
   logic       y_valid;

   int checks   = 0;
   int failures = 0;

   decoder_2to4 #(
      .IN_W    (2),
      .OUT_W   (4),
      .REG_OUT (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .en      (en),
      .y       (y),
      .y_valid (y_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the outputs are the decode of whatever was presented at the last edge.
   logic [3:0] exp_y;
   logic       exp_v;
   logic       model_live = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_y      <= 4'd0;
         exp_v      <= 1'b0;
         model_live <= 1'b1;
      end else begin
         exp_y <= en ? 4'(1 << a) : 4'd0;
         exp_v <= en;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (model_live) begin
         checks++;
         if (y !== exp_y || y_valid !== exp_v) begin
            failures++;
            $display("FAIL model_cmp t=%0t: y=%b y_valid=%b, required y=%b y_valid=%b",
                     $time, y, y_valid, exp_y, exp_v);
         end
         checks++;
         if (!$onehot0(y)) begin
            failures++;
            $display("FAIL onehot0 t=%0t: y=%b is multi-hot", $time, y);
         end
      end
   end

   // Directed vectors: inputs for one edge and the hand-computed outputs just after it.
   logic       v_rst [NVEC];
   logic       v_en  [NVEC];
   logic [1:0] v_a   [NVEC];
   logic [3:0] v_y   [NVEC];
   logic       v_vld [NVEC];

   task automatic set_vec(input int i, input logic r, input logic e, input logic [1:0] s,
                          input logic [3:0] ey, input logic ev);
      v_rst[i] = r;
      v_en[i]  = e;
      v_a[i]   = s;
      v_y[i]   = ey;
      v_vld[i] = ev;
   endtask

   initial begin
      // reset held two cycles with en=1, a=11, then first live edge
      set_vec(0,  1'b1, 1'b1, 2'b11, 4'b0000, 1'b0);
      set_vec(1,  1'b1, 1'b1, 2'b11, 4'b0000, 1'b0);
      set_vec(2,  1'b0, 1'b1, 2'b11, 4'b1000, 1'b1);
      // disabled sweep
      set_vec(3,  1'b0, 1'b0, 2'b00, 4'b0000, 1'b0);
      set_vec(4,  1'b0, 1'b0, 2'b01, 4'b0000, 1'b0);
      set_vec(5,  1'b0, 1'b0, 2'b10, 4'b0000, 1'b0);
      set_vec(6,  1'b0, 1'b0, 2'b11, 4'b0000, 1'b0);
      // full enabled sweep
      set_vec(7,  1'b0, 1'b1, 2'b00, 4'b0001, 1'b1);
      set_vec(8,  1'b0, 1'b1, 2'b01, 4'b0010, 1'b1);
      set_vec(9,  1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);
      set_vec(10, 1'b0, 1'b1, 2'b11, 4'b1000, 1'b1);
      // enable toggle with a=01 held
      set_vec(11, 1'b0, 1'b1, 2'b01, 4'b0010, 1'b1);
      set_vec(12, 1'b0, 1'b0, 2'b01, 4'b0000, 1'b0);
      set_vec(13, 1'b0, 1'b1, 2'b01, 4'b0010, 1'b1);
      // back-to-back select changes
      set_vec(14, 1'b0, 1'b1, 2'b00, 4'b0001, 1'b1);
      set_vec(15, 1'b0, 1'b1, 2'b11, 4'b1000, 1'b1);
      set_vec(16, 1'b0, 1'b1, 2'b01, 4'b0010, 1'b1);
      set_vec(17, 1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);
      // mid-operation reset pulse
      set_vec(18, 1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);
      set_vec(19, 1'b1, 1'b1, 2'b10, 4'b0000, 1'b0);
      set_vec(20, 1'b0, 1'b1, 2'b10, 4'b0100, 1'b1);

      rst = 1'b1;
      en  = 1'b0;
      a   = 2'b00;
      @(negedge clk);

      for (int i = 0; i < NVEC; i++) begin
         rst = v_rst[i];
         en  = v_en[i];
         a   = v_a[i];
         @(posedge clk);
         #1;
         checks++;
         if (y !== v_y[i] || y_valid !== v_vld[i]) begin
            failures++;
            $display("FAIL vec%0d: y=%b y_valid=%b, required y=%b y_valid=%b",
                     i, y, y_valid, v_y[i], v_vld[i]);
         end
      end

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
